out_chain_arb: RTL and testbench
================================

// Module: out_chain_arb
// PURPOSE
//  Per-node arbiter for the daisy-chained output FIFO path (out_node_fifo chain).
//  Shares the node's downstream FIFO write port between two sources.
//  - Forward: upstream FIFO traffic, read show-ahead.
//  - Local: words from this node's own valid/ack source.
//  Bounded-burst fairness stops a busy upstream from starving local injection.
//  One instance sits between FIFO[i-1] and FIFO[i] at each chain node.
// PARAMETERS
//  DATA_W   8   word width on all data ports
//  FWD_MAX  4   max consecutive forwards granted while local is pending (>=1)
//  LOC_MAX  1   max consecutive local grants before forward priority returns (>=1)
//  CNT_W    16  width of saturating transfer counters
// PORTS
//  clock      in   1       single clock; all logic on posedge
//  sclr       in   1       synchronous, active-high reset
//  up_q       in   DATA_W  upstream FIFO show-ahead output
//  up_empty   in   1       upstream FIFO empty
//  up_rdreq   out  1       pop upstream FIFO (combinational)
//  loc_data   in   DATA_W  local source word
//  loc_valid  in   1       local word available
//  loc_ack    out  1       local word consumed this cycle (combinational)
//  dn_data    out  DATA_W  downstream FIFO write data
//  dn_wrreq   out  1       downstream FIFO write strobe (combinational)
//  dn_full    in   1       downstream FIFO full
//  fwd_cnt    out  CNT_W   forwarded words since reset, saturating
//  loc_cnt    out  CNT_W   local words since reset, saturating
//  prio_loc   out  1       1 = arbiter currently in LOC_PRIO
// BEHAVIOUR
//  Grants
//  - Zero-latency combinational grant; at most one transfer per cycle.
//  - fwd_go = !dn_full && !up_empty && sel_fwd; loc_go = !dn_full && loc_valid && !sel_fwd.
//  - up_rdreq = fwd_go; loc_ack = loc_go; dn_wrreq = fwd_go | loc_go.
//  - dn_data = up_q on fwd_go, loc_data on loc_go, else all-zero (never X or Z).
//  - Work-conserving: if the preferred source has nothing, the other source is served.
//  - dn_full=1: no strobes; state, run_cnt and counters hold.
//  State machine: FWD_PRIO (reset state) and LOC_PRIO; run counter run_cnt.
//  - FWD_PRIO: sel_fwd = !up_empty.
//    - Forward while loc_valid=1: run_cnt++. If run_cnt was FWD_MAX-1, go LOC_PRIO, run_cnt=0.
//    - Forward while loc_valid=0: run_cnt=0.
//    - Local grant (upstream empty): run_cnt=0, stay in FWD_PRIO.
//  - LOC_PRIO: sel_fwd = !loc_valid.
//    - Local grant: run_cnt++. If run_cnt was LOC_MAX-1, go FWD_PRIO, run_cnt=0.
//    - loc_valid=0: serve upstream if non-empty, go FWD_PRIO, run_cnt=0 (same cycle).
//  - Both sources idle: state holds, run_cnt holds.
//  - Never asserts up_rdreq when up_empty=1 or loc_ack when loc_valid=0.
//  Counters
//  - fwd_cnt +1 per fwd_go, loc_cnt +1 per loc_go.
//  - Both saturate at 2^CNT_W-1 and never wrap.
//  Reset (sclr=1 sampled at a clock edge)
//  - Next cycle: state FWD_PRIO, run_cnt=0, fwd_cnt=0, loc_cnt=0, prio_loc=0.
//  - During sclr=1, all strobes are forced 0 and dn_data=0.
//  - Mid-stream sclr drops no accepted word: nothing is strobed while sclr=1.
// STRUCTURE
//  - Package out_chain_pkg: typedef enum logic {FWD_PRIO, LOC_PRIO} arb_state_t.
//  - Same package: default DATA_W/CNT_W localparams for chain top-levels.
//  - Sub-module sat_counter #(CNT_W): inc, sclr -> value; instantiated twice.
//  - Remainder is flat: one always_ff for state/run_cnt, one always_comb for grants/mux.
// TESTING
//  1. up_empty=1, loc_valid with data 0..5, dn_full=0.
//     -> 6 dn_wrreq cycles, dn_data 0,1,..,5 in order, loc_cnt=6, fwd_cnt=0.
//  2. Both sources always ready, FWD_MAX=4, LOC_MAX=1, 20 cycles.
//     -> grant pattern F,F,F,F,L repeating; fwd_cnt=16, loc_cnt=4.
//  3. As test 2, with dn_full=1 for 3 cycles after the 2nd forward.
//     -> no strobes for those 3 cycles; pattern resumes at 3rd F, not reset.
//  4. In LOC_PRIO, drop loc_valid with up_empty=0.
//     -> up_rdreq=1 that same cycle, prio_loc=0 next cycle.
//  5. sclr pulse mid-test-2.
//     -> next cycle counters=0, prio_loc=0; no strobes while sclr=1; pattern restarts F,F,F,F,L.
//  6. Chain of 8 nodes (arb + out_node_fifo), each injecting 6 words tagged with node index.
//     -> sink pops exactly 6 words per tag, none lost or duplicated; every loc_cnt=6.

Source files
------------

// File: rtl/out_chain_pkg.sv
// Shared types and defaults for the daisy-chained output FIFO path.
// Used by the per-node arbiter and by chain top-levels.
package out_chain_pkg;

    typedef enum logic {
        FWD_PRIO = 1'b0,
        LOC_PRIO = 1'b1
    } arb_state_t;

    localparam int CHAIN_DATA_W = 8;
    localparam int CHAIN_CNT_W  = 16;

    // Width of a run counter that must reach max(fwd_max, loc_max) - 1
    function automatic int run_width(input int fwd_max, input int loc_max);
        int m;
        m = (fwd_max > loc_max) ? fwd_max : loc_max;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones, clears on sclr.
module sat_counter
    import out_chain_pkg::*;
#(
    parameter int CNT_W = CHAIN_CNT_W
) (
    input  logic             clock,
    input  logic             sclr,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    always_ff @(posedge clock) begin
        if (sclr) begin
            value <= '0;
        end else if (inc && (value != {CNT_W{1'b1}})) begin
            value <= value + CNT_W'(1);
        end
    end

endmodule

// File: rtl/out_chain_arb.sv
// Per-node arbiter sharing the downstream FIFO write port between upstream
// forward traffic and local injection, with bounded-burst fairness.
module out_chain_arb
    import out_chain_pkg::*;
#(
    parameter int DATA_W  = CHAIN_DATA_W,
    parameter int FWD_MAX = 4,
    parameter int LOC_MAX = 1,
    parameter int CNT_W   = CHAIN_CNT_W
) (
    input  logic              clock,
    input  logic              sclr,
    input  logic [DATA_W-1:0] up_q,
    input  logic              up_empty,
    output logic              up_rdreq,
    input  logic [DATA_W-1:0] loc_data,
    input  logic              loc_valid,
    output logic              loc_ack,
    output logic [DATA_W-1:0] dn_data,
    output logic              dn_wrreq,
    input  logic              dn_full,
    output logic [CNT_W-1:0]  fwd_cnt,
    output logic [CNT_W-1:0]  loc_cnt,
    output logic              prio_loc
);

    localparam int RUN_W = run_width(FWD_MAX, LOC_MAX);
    localparam logic [RUN_W-1:0] FWD_LAST = RUN_W'(FWD_MAX - 1);
    localparam logic [RUN_W-1:0] LOC_LAST = RUN_W'(LOC_MAX - 1);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_nxt;
    logic             sel_fwd;
    logic             fwd_go;
    logic             loc_go;

    always_ff @(posedge clock) begin
        if (sclr) begin
            state   <= FWD_PRIO;
            run_cnt <= '0;
        end else begin
            state   <= state_nxt;
            run_cnt <= run_nxt;
        end
    end

    // No grant means no transition, so dn_full and idle cycles hold state for free
    always_comb begin
        state_nxt = state;
        run_nxt   = run_cnt;
        case (state)
            FWD_PRIO: begin
                if (fwd_go) begin
                    if (!loc_valid) begin
                        run_nxt = '0;
                    end else if (run_cnt == FWD_LAST) begin
                        state_nxt = LOC_PRIO;
                        run_nxt   = '0;
                    end else begin
                        run_nxt = run_cnt + RUN_W'(1);
                    end
                end else if (loc_go) begin
                    run_nxt = '0;
                end
            end
            LOC_PRIO: begin
                if (loc_go) begin
                    if (run_cnt == LOC_LAST) begin
                        state_nxt = FWD_PRIO;
                        run_nxt   = '0;
                    end else begin
                        run_nxt = run_cnt + RUN_W'(1);
                    end
                end else if (fwd_go) begin
                    state_nxt = FWD_PRIO;
                    run_nxt   = '0;
                end
            end
            default: begin
                state_nxt = FWD_PRIO;
                run_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        sel_fwd  = (state == FWD_PRIO) ? !up_empty : !loc_valid;
        fwd_go   = !sclr && !dn_full && !up_empty && sel_fwd;
        loc_go   = !sclr && !dn_full && loc_valid && !sel_fwd;
        up_rdreq = fwd_go;
        loc_ack  = loc_go;
        dn_wrreq = fwd_go || loc_go;
        dn_data  = '0;
        if (fwd_go) begin
            dn_data = up_q;
        end else if (loc_go) begin
            dn_data = loc_data;
        end
        prio_loc = (state == LOC_PRIO);
    end

    sat_counter #(.CNT_W(CNT_W)) u_fwd_cnt (
        .clock (clock),
        .sclr  (sclr),
        .inc   (fwd_go),
        .value (fwd_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_loc_cnt (
        .clock (clock),
        .sclr  (sclr),
        .inc   (loc_go),
        .value (loc_cnt)
    );

endmodule

// File: tb/tb_out_chain_arb.sv
// Directed bench for out_chain_arb: single-node vector table, counter saturation
// on a narrow instance, and an 8-node chain with behavioural FIFOs.
module tb_out_chain_arb;

    logic        clock;
    logic        sclr;
    logic [7:0]  up_q;
    logic        up_empty;
    logic        up_rdreq;
    logic [7:0]  loc_data;
    logic        loc_valid;
    logic        loc_ack;
    logic [7:0]  dn_data;
    logic        dn_wrreq;
    logic        dn_full;
    logic [15:0] fwd_cnt;
    logic [15:0] loc_cnt;
    logic        prio_loc;

    logic        s_up_rdreq;
    logic        s_loc_ack;
    logic [7:0]  s_dn_data;
    logic        s_dn_wrreq;
    logic [1:0]  s_fwd_cnt;
    logic [1:0]  s_loc_cnt;
    logic        s_prio_loc;

    int n_chk  = 0;
    int n_fail = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    out_chain_arb #(.DATA_W(8), .FWD_MAX(4), .LOC_MAX(1), .CNT_W(16)) dut (
        .clock(clock), .sclr(sclr), .up_q(up_q), .up_empty(up_empty), .up_rdreq(up_rdreq),
        .loc_data(loc_data), .loc_valid(loc_valid), .loc_ack(loc_ack), .dn_data(dn_data),
        .dn_wrreq(dn_wrreq), .dn_full(dn_full), .fwd_cnt(fwd_cnt), .loc_cnt(loc_cnt),
        .prio_loc(prio_loc)
    );

    out_chain_arb #(.DATA_W(8), .FWD_MAX(4), .LOC_MAX(1), .CNT_W(2)) dut_sat (
        .clock(clock), .sclr(sclr), .up_q(up_q), .up_empty(up_empty), .up_rdreq(s_up_rdreq),
        .loc_data(loc_data), .loc_valid(loc_valid), .loc_ack(s_loc_ack), .dn_data(s_dn_data),
        .dn_wrreq(s_dn_wrreq), .dn_full(dn_full), .fwd_cnt(s_fwd_cnt), .loc_cnt(s_loc_cnt),
        .prio_loc(s_prio_loc)
    );

    // ---------------- 8-node chain ----------------
    logic        chain_sclr;
    logic        sink_rd;
    logic [7:0]  c_up_q      [8];
    logic        c_up_empty  [8];
    logic        c_up_rdreq  [8];
    logic [7:0]  c_loc_data  [8];
    logic        c_loc_valid [8];
    logic        c_loc_ack   [8];
    logic [7:0]  c_dn_data   [8];
    logic        c_dn_wrreq  [8];
    logic        c_dn_full   [8];
    logic [15:0] c_fwd_cnt   [8];
    logic [15:0] c_loc_cnt   [8];
    logic        c_prio      [8];
    logic [7:0]  f_q         [8];
    logic        f_empty     [8];
    logic        f_rd        [8];

    assign sink_rd = !chain_sclr && !f_empty[7];

    for (genvar i = 0; i < 8; i++) begin : g_node
        logic [7:0] mem [4];
        logic [2:0] cnt;
        logic [1:0] wp;
        logic [1:0] rp;
        logic [2:0] sent;

        if (i == 0) begin : g_head
            assign c_up_q[i]     = 8'h00;
            assign c_up_empty[i] = 1'b1;
        end else begin : g_link
            assign c_up_q[i]     = f_q[i-1];
            assign c_up_empty[i] = f_empty[i-1];
        end
        if (i == 7) begin : g_tail
            assign f_rd[i] = sink_rd;
        end else begin : g_mid
            assign f_rd[i] = c_up_rdreq[i+1];
        end

        assign c_loc_valid[i] = (sent < 3'd6);
        assign c_loc_data[i]  = {3'(i), 2'b00, sent};
        assign f_q[i]         = mem[rp];
        assign f_empty[i]     = (cnt == 3'd0);
        assign c_dn_full[i]   = (cnt == 3'd4);

        always @(posedge clock) begin
            if (chain_sclr) begin
                cnt  <= 3'd0;
                wp   <= 2'd0;
                rp   <= 2'd0;
                sent <= 3'd0;
            end else begin
                if (c_dn_wrreq[i]) begin
                    mem[wp] <= c_dn_data[i];
                    wp      <= wp + 2'd1;
                end
                if (f_rd[i]) rp <= rp + 2'd1;
                cnt <= cnt + {2'b00, c_dn_wrreq[i]} - {2'b00, f_rd[i]};
                if (c_loc_ack[i]) sent <= sent + 3'd1;
            end
        end

        out_chain_arb #(.DATA_W(8), .FWD_MAX(4), .LOC_MAX(1), .CNT_W(16)) u_arb (
            .clock(clock), .sclr(chain_sclr), .up_q(c_up_q[i]), .up_empty(c_up_empty[i]),
            .up_rdreq(c_up_rdreq[i]), .loc_data(c_loc_data[i]), .loc_valid(c_loc_valid[i]),
            .loc_ack(c_loc_ack[i]), .dn_data(c_dn_data[i]), .dn_wrreq(c_dn_wrreq[i]),
            .dn_full(c_dn_full[i]), .fwd_cnt(c_fwd_cnt[i]), .loc_cnt(c_loc_cnt[i]),
            .prio_loc(c_prio[i])
        );
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        sclr;
        logic        up_empty;
        logic [7:0]  up_q;
        logic        loc_valid;
        logic [7:0]  loc_data;
        logic        dn_full;
        logic        e_fwd;
        logic        e_loc;
        logic        e_prio;
        int          e_fc;
        int          e_lc;
    } vec_t;

    vec_t tbl[$];
    int   run_f;
    int   run_l;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Counter expectations are the running totals of the hand-written grants
    task automatic add(input logic s, input logic ue, input logic lv, input logic full,
                       input logic ef, input logic el, input logic ep);
        vec_t v;
        int   k;
        k           = tbl.size();
        v.sclr      = s;
        v.up_empty  = ue;
        v.up_q      = 8'(k) ^ 8'hA5;
        v.loc_valid = lv;
        v.loc_data  = 8'(k) ^ 8'h3C;
        v.dn_full   = full;
        v.e_fwd     = ef;
        v.e_loc     = el;
        v.e_prio    = ep;
        v.e_fc      = run_f;
        v.e_lc      = run_l;
        if (s) begin
            run_f = 0;
            run_l = 0;
        end else begin
            run_f += int'(ef);
            run_l += int'(el);
        end
        tbl.push_back(v);
    endtask

    task automatic fwd4();
        for (int j = 0; j < 4; j++) add(0, 0, 1, 0, 1, 0, 0);
    endtask

    task automatic pattern(input int reps);
        for (int j = 0; j < reps; j++) begin
            fwd4();
            add(0, 0, 1, 0, 0, 1, 1);
        end
    endtask

    int rx [8];
    int rx_total;

    initial begin
        // Table starts right after the local-only test: 0 forwards, 6 locals
        run_f = 0;
        run_l = 6;
        add(1, 0, 1, 0, 0, 0, 0);
        pattern(4);
        add(1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0);
        for (int j = 0; j < 3; j++) add(0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 1, 0, 0, 1, 1);
        pattern(1);
        add(1, 0, 1, 0, 0, 0, 0);
        fwd4();
        add(0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 1, 0, 1, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0);
        fwd4();
        add(1, 0, 1, 0, 0, 0, 1);
        pattern(1);
        fwd4();
        add(0, 1, 0, 0, 0, 0, 1);
        add(0, 1, 0, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 1, 1);
        add(0, 1, 1, 0, 0, 1, 0);
        fwd4();
        add(0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 1, 0, 0, 1, 1);
        add(0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0);
        pattern(1);

        chain_sclr = 1'b1;
        sclr       = 1'b1;
        up_empty   = 1'b0;
        up_q       = 8'h77;
        loc_valid  = 1'b1;
        loc_data   = 8'h11;
        dn_full    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        chk("rst_up_rdreq", 32'(up_rdreq), 32'd0);
        chk("rst_loc_ack", 32'(loc_ack), 32'd0);
        chk("rst_dn_wrreq", 32'(dn_wrreq), 32'd0);
        chk("rst_dn_data", 32'(dn_data), 32'd0);
        chk("rst_prio_loc", 32'(prio_loc), 32'd0);
        chk("rst_fwd_cnt", 32'(fwd_cnt), 32'd0);
        chk("rst_loc_cnt", 32'(loc_cnt), 32'd0);

        // Local-only stream, upstream empty
        @(posedge clock);
        #1;
        sclr     = 1'b0;
        up_empty = 1'b1;
        for (int k = 0; k < 6; k++) begin
            loc_valid = 1'b1;
            loc_data  = 8'(k);
            @(negedge clock);
            chk($sformatf("t1_wrreq_%0d", k), 32'(dn_wrreq), 32'd1);
            chk($sformatf("t1_ack_%0d", k), 32'(loc_ack), 32'd1);
            chk($sformatf("t1_rdreq_%0d", k), 32'(up_rdreq), 32'd0);
            chk($sformatf("t1_data_%0d", k), 32'(dn_data), k);
            @(posedge clock);
            #1;
        end
        loc_valid = 1'b0;
        @(negedge clock);
        chk("t1_idle_wrreq", 32'(dn_wrreq), 32'd0);
        chk("t1_idle_data", 32'(dn_data), 32'd0);
        chk("t1_loc_cnt", 32'(loc_cnt), 32'd6);
        chk("t1_fwd_cnt", 32'(fwd_cnt), 32'd0);
        chk("sat_loc_cnt", 32'(s_loc_cnt), 32'd3);
        chk("sat_fwd_cnt", 32'(s_fwd_cnt), 32'd0);
        @(posedge clock);
        #1;

        foreach (tbl[n]) begin
            sclr      = tbl[n].sclr;
            up_empty  = tbl[n].up_empty;
            up_q      = tbl[n].up_q;
            loc_valid = tbl[n].loc_valid;
            loc_data  = tbl[n].loc_data;
            dn_full   = tbl[n].dn_full;
            @(negedge clock);
            chk($sformatf("v%0d_up_rdreq", n), 32'(up_rdreq), 32'(tbl[n].e_fwd));
            chk($sformatf("v%0d_loc_ack", n), 32'(loc_ack), 32'(tbl[n].e_loc));
            chk($sformatf("v%0d_dn_wrreq", n), 32'(dn_wrreq), 32'(tbl[n].e_fwd | tbl[n].e_loc));
            chk($sformatf("v%0d_dn_data", n), 32'(dn_data),
                tbl[n].e_fwd ? 32'(tbl[n].up_q) : (tbl[n].e_loc ? 32'(tbl[n].loc_data) : 32'd0));
            chk($sformatf("v%0d_prio_loc", n), 32'(prio_loc), 32'(tbl[n].e_prio));
            chk($sformatf("v%0d_fwd_cnt", n), 32'(fwd_cnt), tbl[n].e_fc);
            chk($sformatf("v%0d_loc_cnt", n), 32'(loc_cnt), tbl[n].e_lc);
            @(posedge clock);
            #1;
        end
        sclr      = 1'b0;
        loc_valid = 1'b0;
        up_empty  = 1'b1;

        // Chain: every node injects 6 tagged words, sink drains the tail FIFO
        for (int t = 0; t < 8; t++) rx[t] = 0;
        rx_total   = 0;
        chain_sclr = 1'b0;
        for (int c = 0; c < 1000 && rx_total < 48; c++) begin
            @(negedge clock);
            if (sink_rd) begin
                chk($sformatf("chain_seq_tag%0d", f_q[7][7:5]), 32'(f_q[7][2:0]), rx[f_q[7][7:5]]);
                rx[f_q[7][7:5]]++;
                rx_total++;
            end
        end
        repeat (20) begin
            @(negedge clock);
            if (sink_rd) begin
                chk("chain_extra_word", 32'(f_q[7]), 32'hFFFF_FFFF);
                rx_total++;
            end
        end
        chk("chain_total", rx_total, 32'd48);
        for (int t = 0; t < 8; t++) begin
            chk($sformatf("chain_rx_tag%0d", t), rx[t], 32'd6);
            chk($sformatf("chain_loc_cnt%0d", t), 32'(c_loc_cnt[t]), 32'd6);
        end
        chk("chain_fwd_cnt7", 32'(c_fwd_cnt[7]), 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

endmodule
